v_mem_seq: RTL and testbench

Multi-beat sequencer sitting directly upstream of the vector memory stage (`v_mem`). It accepts one vector memory request (load, store or multiply-accumulate pass), expands it into per-beat VRAM accesses at `base + k*stride`, and drives them into `v_mem` one beat per cycle. It handles store-data and load-result handshakes. For accumulate opcodes it feeds each beat's result back as `vd_data` for the next beat, and delivers only the final sum.

---
 rtl/v_mem_seq_if.sv | 44 ++++
 rtl/v_mem_seq.sv | 74 +++++++
 tb/tb_v_mem_seq.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/v_mem_seq_if.sv
// v_mem_seq_if: request, store, result and v_mem-side signals of the vector memory sequencer
interface v_mem_seq_if #(
  parameter int DW = 512,
  parameter int AW = 64,
  parameter int RW = 1024,
  parameter int BW = 8
);
  logic          req_valid;
  logic          req_ready;
  logic          req_store;
  logic [4:0]    req_opcode;
  logic [AW-1:0] req_base;
  logic [AW-1:0] req_stride;
  logic [BW-1:0] req_beats;
  logic [31:0]   req_vs2select;
  logic [RW-1:0] req_vd_init;
  logic          st_valid;
  logic          st_ready;
  logic [DW-1:0] st_data;
  logic          ld_valid;
  logic          ld_ready;
  logic [RW-1:0] ld_data;
  logic          done;
  logic          vmem_ren;
  logic          vmem_wen;
  logic [AW-1:0] vmem_addr;
  logic [DW-1:0] vmem_din;
  logic [4:0]    vmem_opcode;
  logic [31:0]   vmem_vs2select;
  logic [RW-1:0] vd_data;
  logic [RW-1:0] vmem_dout;
  modport master (
    output req_valid, req_store, req_opcode, req_base, req_stride, req_beats, req_vs2select,
           req_vd_init, st_valid, st_data, ld_ready, vmem_dout,
    input  req_ready, st_ready, ld_valid, ld_data, done, vmem_ren, vmem_wen, vmem_addr,
           vmem_din, vmem_opcode, vmem_vs2select, vd_data
  );
  modport slave (
    input  req_valid, req_store, req_opcode, req_base, req_stride, req_beats, req_vs2select,
           req_vd_init, st_valid, st_data, ld_ready, vmem_dout,
    output req_ready, st_ready, ld_valid, ld_data, done, vmem_ren, vmem_wen, vmem_addr,
           vmem_din, vmem_opcode, vmem_vs2select, vd_data
  );
endinterface

// File: rtl/v_mem_seq.sv
// v_mem_seq: expands one vector memory request into strided per-beat v_mem accesses
module v_mem_seq #(
  parameter int DW = 512,
  parameter int AW = 64,
  parameter int RW = 1024,
  parameter int BW = 8
) (
  input logic         clk,
  input logic         rst,
  v_mem_seq_if.slave  bus
);
  typedef enum logic [2:0] {IDLE, LOAD, STORE, ACC, DONE} state_t;
  state_t        state, state_n;
  logic [4:0]    opcode;
  logic [31:0]   vs2select;
  logic [AW-1:0] stride, addr;
  logic [BW-1:0] beats_left;
  logic [RW-1:0] acc, ld_data;
  logic          ld_valid;
  logic          accept, free, beat, last, is_acc, capture;
  assign free    = !ld_valid || bus.ld_ready;
  assign accept  = state == IDLE && bus.req_valid;
  assign is_acc  = !bus.req_store && (bus.req_opcode inside {5'd1, 5'd4, 5'd5});
  assign beat    = (state == STORE && bus.st_valid) || (state == LOAD && free) || state == ACC;
  assign last    = beat && beats_left == BW'(1);
  // loads fill the buffer every beat; accumulates only with the final sum
  assign capture = (state == LOAD && beat) || (state == ACC && last);
  always_comb begin
    state_n = state;
    if (accept) state_n = bus.req_beats == '0 ? DONE : bus.req_store ? STORE : is_acc ? ACC : LOAD;
    else if (last) state_n = DONE;
    else if (state == DONE && free) state_n = IDLE;
  end
  always_ff @(posedge clk) state <= !rst ? IDLE : state_n;
  always_ff @(posedge clk) begin
    if (!rst) begin
      opcode     <= '0;
      vs2select  <= '0;
      stride     <= '0;
      addr       <= '0;
      beats_left <= '0;
      acc        <= '0;
      ld_data    <= '0;
      ld_valid   <= 1'b0;
    end else begin
      if (accept) begin
        opcode     <= bus.req_opcode;
        vs2select  <= bus.req_vs2select;
        stride     <= bus.req_stride;
        beats_left <= bus.req_beats;
        addr       <= bus.req_base;
        acc        <= bus.req_vd_init;
      end else if (beat) begin
        addr       <= addr + stride;
        beats_left <= beats_left - BW'(1);
        if (state == ACC) acc <= bus.vmem_dout;
      end
      if (capture) ld_data <= bus.vmem_dout;
      ld_valid <= capture ? 1'b1 : ld_valid && !bus.ld_ready;
    end
  end
  assign bus.req_ready      = state == IDLE;
  assign bus.st_ready       = state == STORE;
  assign bus.vmem_wen       = state == STORE && bus.st_valid;
  assign bus.vmem_ren       = (state == LOAD && free) || state == ACC;
  assign bus.vmem_din       = bus.vmem_wen ? bus.st_data : '0;
  assign bus.vmem_addr      = addr;
  assign bus.vmem_opcode    = opcode;
  assign bus.vmem_vs2select = vs2select;
  assign bus.vd_data        = acc;
  assign bus.ld_valid       = ld_valid;
  assign bus.ld_data        = ld_data;
  assign bus.done           = state == DONE && free;
endmodule

// File: tb/tb_v_mem_seq.sv
// tb_v_mem_seq: randomized scenarios for v_mem_seq checked against a request-level reference model
module tb_v_mem_seq;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int n_vec = 0, n_err = 0;
  v_mem_seq_if bus ();
  v_mem_seq dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [1023:0] mem_word(input logic [63:0] a);
    return {16{a ^ 64'h0123_4567_89AB_CDEF}};
  endfunction
  function automatic logic [1023:0] lanes_add(input logic [1023:0] v, input int n);
    logic [1023:0] r;
    for (int i = 0; i < 64; i++) r[i*16 +: 16] = v[i*16 +: 16] + 16'(n);
    return r;
  endfunction
  function automatic logic [511:0] rnd512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction
  function automatic logic [1023:0] rnd1024();
    return {rnd512(), rnd512()};
  endfunction
  // v_mem stand-in: accumulate opcodes add 5 per 16-bit lane, others read a fixed address pattern
  always_comb bus.vmem_dout = (bus.vmem_opcode inside {5'd1, 5'd4, 5'd5}) ? lanes_add(bus.vd_data, 5) : mem_word(bus.vmem_addr);
  logic [63:0]   addr_q[$];
  logic [511:0]  din_q[$], sdata[$];
  logic [1023:0] ld_q[$], vd_q[$];
  int cyc_q[$], ldc_q[$];
  int done_cyc, rdy0, rdy_bad, stab_bad, op_bad;
  task automatic run_req(input logic st, input logic [4:0] op, input logic [63:0] base, input logic [63:0] stride,
                         input logic [7:0] beats, input logic [1023:0] init, input logic [31:0] vs2,
                         input int gap, input int bp, input logic [31:0] hold);
    logic prev_v;
    logic [1023:0] prev_d;
    int k;
    addr_q.delete(); din_q.delete(); ld_q.delete(); vd_q.delete(); cyc_q.delete(); ldc_q.delete();
    while (sdata.size() < int'(beats)) sdata.push_back(rnd512());
    bus.req_store = st; bus.req_opcode = op; bus.req_base = base; bus.req_stride = stride;
    bus.req_beats = beats; bus.req_vd_init = init; bus.req_vs2select = vs2; bus.req_valid = 1'b1;
    @(negedge clk);
    rdy0 = int'(bus.req_ready);
    @(posedge clk); #1;
    bus.req_valid = 1'b0; bus.req_store = 1'($urandom); bus.req_opcode = 5'($urandom);
    bus.req_base = {$urandom, $urandom}; bus.req_stride = {$urandom, $urandom};
    bus.req_beats = 8'($urandom); bus.req_vd_init = rnd1024(); bus.req_vs2select = $urandom;
    done_cyc = -1; rdy_bad = 0; stab_bad = 0; op_bad = 0; k = 0; prev_v = 1'b0; prev_d = '0;
    for (int c = 1; c <= 300 && done_cyc < 0; c++) begin
      bus.st_valid = $urandom_range(99) >= gap;
      bus.st_data  = k < sdata.size() ? sdata[k] : rnd512();
      bus.ld_ready = !(c < 32 && hold[c[4:0]]) && $urandom_range(99) >= bp;
      @(negedge clk);
      if (bus.vmem_wen || bus.vmem_ren) begin
        addr_q.push_back(bus.vmem_addr);
        cyc_q.push_back(c);
        if (bus.vmem_opcode !== op || bus.vmem_vs2select !== vs2) op_bad++;
      end
      if (bus.vmem_wen) begin
        din_q.push_back(bus.vmem_din);
        k++;
      end
      if (bus.vmem_ren) vd_q.push_back(bus.vd_data);
      if (prev_v && (bus.ld_valid !== 1'b1 || bus.ld_data !== prev_d)) stab_bad++;
      prev_v = bus.ld_valid && !bus.ld_ready;
      prev_d = bus.ld_data;
      if (bus.ld_valid && bus.ld_ready) begin
        ld_q.push_back(bus.ld_data);
        ldc_q.push_back(c);
      end
      if (bus.req_ready) rdy_bad++;
      if (bus.done) done_cyc = c;
      @(posedge clk); #1;
    end
    bus.st_valid = 1'b0;
    bus.ld_ready = 1'b1;
  endtask
  task automatic test_reset();
    bus.req_valid = 0; bus.req_store = 0; bus.req_opcode = 0; bus.req_base = 0; bus.req_stride = 0;
    bus.req_beats = 0; bus.req_vs2select = 0; bus.req_vd_init = '0; bus.st_valid = 0; bus.st_data = '0;
    bus.ld_ready = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if ({bus.req_ready, bus.st_ready, bus.ld_valid, bus.done, bus.vmem_ren, bus.vmem_wen} !== 6'b100000) begin
      n_err++;
      $display("FAIL reset_ctrl got %b want 100000", {bus.req_ready, bus.st_ready, bus.ld_valid, bus.done, bus.vmem_ren, bus.vmem_wen});
    end
    n_vec++;
    if ({bus.vmem_addr, bus.vmem_opcode, bus.vmem_vs2select, bus.vmem_din, bus.vd_data, bus.ld_data} !== '0) begin
      n_err++;
      $display("FAIL reset_data got addr=%h op=%h nonzero outputs want all 0", bus.vmem_addr, bus.vmem_opcode);
    end
    @(posedge clk); #1;
    rst = 1'b1;
  endtask
  task automatic test_store();
    sdata.delete();
    sdata.push_back(512'hA); sdata.push_back(512'hB); sdata.push_back(512'hC);
    run_req(1'b1, 5'd2, 64'h1000, 64'd64, 8'd3, '0, 32'h1234, 0, 0, 0);
    n_vec++;
    if (addr_q.size() != 3 || addr_q[0] !== 64'h1000 || addr_q[1] !== 64'h1040 || addr_q[2] !== 64'h1080) begin
      n_err++;
      $display("FAIL store_addr got %0d beats first=%h want 1000/1040/1080", addr_q.size(), addr_q.size() ? addr_q[0] : 64'hx);
    end
    n_vec++;
    if (cyc_q.size() != 3 || cyc_q[0] != 1 || cyc_q[1] != 2 || cyc_q[2] != 3) begin
      n_err++;
      $display("FAIL store_cycles got %0d wen cycles want T+1..T+3", cyc_q.size());
    end
    n_vec++;
    if (din_q.size() != 3 || din_q[0] !== 512'hA || din_q[1] !== 512'hB || din_q[2] !== 512'hC) begin
      n_err++;
      $display("FAIL store_data got %0d beats want A/B/C", din_q.size());
    end
    n_vec++;
    if (done_cyc != 4 || rdy0 != 1 || rdy_bad != 0 || op_bad != 0) begin
      n_err++;
      $display("FAIL store_done got done=T+%0d rdy0=%0d busy_rdy=%0d op_bad=%0d want T+4 1 0 0", done_cyc, rdy0, rdy_bad, op_bad);
    end
  endtask
  task automatic test_load_bp();
    logic [63:0] base, stride;
    logic ok;
    base = {$urandom, $urandom}; stride = {32'h0, $urandom};
    sdata.delete();
    run_req(1'b0, 5'd0, base, stride, 8'd4, '0, $urandom, 0, 0, 32'hC);
    ok = addr_q.size() == 4;
    for (int k = 0; k < 4 && ok; k++) ok = addr_q[k] === base + 64'(k) * stride;
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL load_bp_addr got %0d reads want 4 at base+k*stride", addr_q.size());
    end
    n_vec++;
    if (cyc_q.size() != 4 || cyc_q[0] != 1 || cyc_q[1] != 4 || cyc_q[2] != 5 || cyc_q[3] != 6) begin
      n_err++;
      $display("FAIL load_bp_stall got %0d ren cycles want T+1,T+4,T+5,T+6", cyc_q.size());
    end
    ok = ld_q.size() == 4;
    for (int k = 0; k < 4 && ok; k++) ok = ld_q[k] === mem_word(base + 64'(k) * stride);
    n_vec++;
    if (!ok || stab_bad != 0) begin
      n_err++;
      $display("FAIL load_bp_data got %0d ld beats unstable=%0d want 4 ordered 0", ld_q.size(), stab_bad);
    end
    n_vec++;
    if (done_cyc != 7) begin
      n_err++;
      $display("FAIL load_bp_done got T+%0d want T+7", done_cyc);
    end
  endtask
  task automatic test_acc();
    logic ok;
    sdata.delete();
    run_req(1'b0, 5'd1, 64'h2000, 64'd128, 8'd3, '0, $urandom, 0, 0, 0);
    n_vec++;
    if (ld_q.size() != 1 || ld_q[0] !== {64{16'd15}}) begin
      n_err++;
      $display("FAIL acc_result got %0d ld beats lane0=%0d want 1 beat lanes 15", ld_q.size(), ld_q.size() ? ld_q[0][15:0] : 16'hx);
    end
    ok = vd_q.size() == 3;
    for (int k = 0; k < 3 && ok; k++) ok = vd_q[k] === {64{16'(5 * k)}};
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL acc_vd got %0d beats want lanes 0,5,10", vd_q.size());
    end
    n_vec++;
    if (cyc_q.size() != 3 || cyc_q[2] != 3 || ldc_q.size() != 1 || ldc_q[0] != 4 || done_cyc != 4) begin
      n_err++;
      $display("FAIL acc_timing got ren=%0d done=T+%0d want 3 beats, ld and done at T+4", cyc_q.size(), done_cyc);
    end
  endtask
  task automatic test_zero();
    for (int s = 0; s < 2; s++) begin
      sdata.delete();
      run_req(1'(s), s ? 5'd2 : 5'd5, {$urandom, $urandom}, 64'd64, 8'd0, rnd1024(), $urandom, 0, 0, 0);
      n_vec++;
      if (addr_q.size() != 0 || ld_q.size() != 0 || done_cyc != 1) begin
        n_err++;
        $display("FAIL zero_beats store=%0d got acc=%0d ld=%0d done=T+%0d want 0 0 T+1", s, addr_q.size(), ld_q.size(), done_cyc);
      end
    end
  endtask
  task automatic test_wrap();
    sdata.delete();
    run_req(1'b0, 5'd0, 64'hFFFF_FFFF_FFFF_FFC0, 64'd64, 8'd2, '0, $urandom, 0, 0, 0);
    n_vec++;
    if (addr_q.size() != 2 || addr_q[0] !== 64'hFFFF_FFFF_FFFF_FFC0 || addr_q[1] !== 64'h0) begin
      n_err++;
      $display("FAIL wrap_addr got %0d reads second=%h want FFC0 then 0", addr_q.size(), addr_q.size() > 1 ? addr_q[1] : 64'hx);
    end
    n_vec++;
    if (ldc_q.size() != 2 || ldc_q[0] != 2 || ldc_q[1] != 3 || done_cyc != 3 || ld_q[1] !== mem_word(64'h0)) begin
      n_err++;
      $display("FAIL wrap_load got %0d ld beats done=T+%0d want T+2,T+3 done T+3", ldc_q.size(), done_cyc);
    end
  endtask
  task automatic test_reset_mid_acc();
    int dn;
    logic [63:0] base;
    bus.req_store = 0; bus.req_opcode = 5'd4; bus.req_base = {$urandom, $urandom}; bus.req_stride = 64'd32;
    bus.req_beats = 8'd5; bus.req_vd_init = rnd1024(); bus.req_vs2select = $urandom; bus.req_valid = 1;
    bus.ld_ready = 1; bus.st_valid = 0;
    @(posedge clk); #1;
    bus.req_valid = 0; dn = 0;
    @(negedge clk); dn += int'(bus.done);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk); dn += int'(bus.done);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk); dn += int'(bus.done);
    n_vec++;
    if ({bus.req_ready, bus.st_ready, bus.ld_valid, bus.done, bus.vmem_ren, bus.vmem_wen} !== 6'b100000 || dn != 0) begin
      n_err++;
      $display("FAIL midreset_ctrl got %b dones=%0d want 100000 0", {bus.req_ready, bus.st_ready, bus.ld_valid, bus.done, bus.vmem_ren, bus.vmem_wen}, dn);
    end
    n_vec++;
    if ({bus.vmem_addr, bus.vmem_opcode, bus.vmem_vs2select, bus.vmem_din, bus.vd_data, bus.ld_data} !== '0) begin
      n_err++;
      $display("FAIL midreset_data got addr=%h op=%h want all outputs 0", bus.vmem_addr, bus.vmem_opcode);
    end
    @(posedge clk); #1;
    base = {$urandom, $urandom};
    sdata.delete();
    run_req(1'b0, 5'd7, base, 64'd16, 8'd3, '0, $urandom, 0, 0, 0);
    n_vec++;
    if (addr_q.size() != 3 || addr_q[2] !== base + 64'd32 || ld_q.size() != 3 || ld_q[2] !== mem_word(base + 64'd32) || done_cyc != 4 || rdy0 != 1) begin
      n_err++;
      $display("FAIL midreset_after got reads=%0d ld=%0d done=T+%0d want 3 3 T+4", addr_q.size(), ld_q.size(), done_cyc);
    end
  endtask
  task automatic test_random();
    for (int it = 0; it < 12; it++) begin
      int cls;
      logic [4:0] op;
      logic [63:0] base, stride;
      logic [7:0] beats;
      logic [1023:0] init;
      logic ok;
      cls = $urandom_range(2);
      op = 5'($urandom);
      if (cls == 0 && (op inside {5'd1, 5'd4, 5'd5})) op = 5'd0;
      if (cls == 2) op = it % 3 == 0 ? 5'd1 : it % 3 == 1 ? 5'd4 : 5'd5;
      base = {$urandom, $urandom}; stride = it % 4 == 0 ? 64'd0 : {$urandom, $urandom};
      beats = 8'($urandom_range(6)); init = rnd1024();
      sdata.delete();
      run_req(cls == 1, op, base, stride, beats, init, $urandom, 30, 30, 0);
      ok = addr_q.size() == int'(beats);
      for (int k = 0; k < int'(beats) && ok; k++) ok = addr_q[k] === base + 64'(k) * stride;
      n_vec++;
      if (!ok) begin
        n_err++;
        $display("FAIL rand%0d_addr cls=%0d got %0d accesses want %0d at base+k*stride", it, cls, addr_q.size(), beats);
      end
      if (cls == 1) begin
        ok = din_q.size() == int'(beats) && ld_q.size() == 0;
        for (int k = 0; k < int'(beats) && ok; k++) ok = din_q[k] === sdata[k];
      end else if (cls == 0) begin
        ok = ld_q.size() == int'(beats);
        for (int k = 0; k < int'(beats) && ok; k++) ok = ld_q[k] === mem_word(base + 64'(k) * stride);
      end else begin
        ok = ld_q.size() == (beats != 0 ? 1 : 0) && vd_q.size() == int'(beats);
        if (ok && beats != 0) ok = ld_q[0] === lanes_add(init, 5 * int'(beats));
        for (int k = 0; k < int'(beats) && ok; k++) ok = vd_q[k] === lanes_add(init, 5 * k);
      end
      n_vec++;
      if (!ok) begin
        n_err++;
        $display("FAIL rand%0d_data cls=%0d beats=%0d got st=%0d ld=%0d vd=%0d", it, cls, beats, din_q.size(), ld_q.size(), vd_q.size());
      end
      n_vec++;
      if (done_cyc < 1 || rdy0 != 1 || rdy_bad != 0 || stab_bad != 0 || op_bad != 0) begin
        n_err++;
        $display("FAIL rand%0d_proto got done=%0d rdy0=%0d busy_rdy=%0d unstable=%0d op_bad=%0d want >0 1 0 0 0", it, done_cyc, rdy0, rdy_bad, stab_bad, op_bad);
      end
    end
  endtask
  initial begin
    test_reset();
    test_store();
    test_load_bp();
    test_acc();
    test_zero();
    test_wrap();
    test_reset_mid_acc();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
